// File: rtl/register_file.sv
// register_file: 32 x 32-bit architectural register file for the unicycle
// processor. Two combinational read ports (rs/rt operands) and one write
// port that updates on the rising clock edge. Register 0 always reads zero
// and ignores writes.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readRegA,
  input  logic [ADDR_WIDTH-1:0] readRegB,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] dataA,
  output logic [DATA_WIDTH-1:0] dataB
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Register storage. Entry 0 exists in the array but is never written
  // after reset and is masked on the read side, so it always reads zero.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Write is qualified by regWrite first, so an unknown destination number
  // while the write is disabled cannot select an entry.
  logic write_hit;
  assign write_hit = regWrite && (writeReg != '0);

  // Storage update: reset clears every entry and takes priority over a write
  // presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[writeReg] <= writeData;
    end
  end

  // Read ports: purely combinational, no bypass from the write port. The
  // address-0 mask guarantees zero even before the first reset.
  always_comb begin
    dataA = '0;
    dataB = '0;
    if (readRegA != '0) dataA = regs[readRegA];
    if (readRegB != '0) dataB = regs[readRegB];
  end

endmodule
